segment_transition: RTL and testbench
=====================================

SEGMENT_TRANSITION -- requirements
Module: segment_transition

Interface
REQ-001 Parameter: NumSegment, 2, number of segments; segment index width is 1 bit.
REQ-002 Port: CLK  input  1  system clock; all state on rising edge.
REQ-003 Port: RESET_N  input  1  asynchronous active-low reset.
REQ-004 Port: UPDATE  input  1  one-cycle pulse; latches all configuration inputs below.
REQ-005 Port: REQ_SEGMENT  input  1  requested segment (ADDR_*_REQ_RD_SEGMENT).
REQ-006 Port: REP  input  16  repetitions of the new segment; 16'hFFFF means infinite.
REQ-007 Port: TRANSITION_MODE  input  8  8'h00 SYNC_IDX, 8'h01 SYS_TIME, 8'h02 GPIO, 8'hF0 EXT.
REQ-008 Port: TRANSITION_VALUE  input  64  mode argument ({VALUE_3..VALUE_0}).
REQ-009 Port: IDX_ZERO  input  1  one-cycle pulse when the active segment's index wraps to 0.
REQ-010 Port: SYS_TIME  input  56  free-running system time.
REQ-011 Port: GPIO_IN  input  4  already-synchronised GPIO inputs.
REQ-012 Port: SEGMENT  output  1  currently active segment.
REQ-013 Port: STOP  output  1  high when the finite repetition count is exhausted.
REQ-014 Port: WAITING  output  1  high while a transition is pending.
REQ-015 Port: SWAP  output  1  one-cycle pulse in the cycle SEGMENT changes.

Function
REQ-016 FSM states SHALL be RUN, WAIT_IDX, WAIT_TIME, WAIT_GPIO; WAITING = state != RUN.
REQ-017 On UPDATE the block SHALL latch REQ_SEGMENT, REP, mode and value, clear STOP and the repetition counter, and enter WAIT_IDX/WAIT_TIME/WAIT_GPIO per mode.
REQ-018 UPDATE with mode EXT SHALL swap immediately: SEGMENT = REQ_SEGMENT and SWAP high in the next cycle, state RUN.
REQ-019 UPDATE with an undefined mode SHALL be ignored entirely (no latch, no state change).
REQ-020 WAIT_IDX: on IDX_ZERO, SEGMENT SHALL take the latched segment one cycle later, SWAP pulse, go to RUN.
REQ-021 WAIT_TIME: when SYS_TIME >= TRANSITION_VALUE[55:0] (unsigned compare), swap one cycle later; a value already in the past swaps on the first WAIT_TIME cycle.
REQ-022 WAIT_GPIO: swap one cycle after a rising edge of GPIO_IN[TRANSITION_VALUE[1:0]]; edge detection uses a registered previous sample, which is updated every cycle in all states.
REQ-023 Swapping to the segment already active SHALL still pulse SWAP and restart repetition counting.
REQ-024 In RUN with REP != 16'hFFFF, each IDX_ZERO after the swap SHALL increment a 16-bit counter; when the count reaches REP+1 the block SHALL act per REQ-025/026.
REQ-025 Non-EXT mode: STOP SHALL assert and hold until the next UPDATE; SEGMENT unchanged.
REQ-026 EXT mode: SEGMENT SHALL toggle, SWAP pulse, counter clear; alternation continues until the next UPDATE; STOP stays low.
REQ-027 REP = 16'hFFFF SHALL never count, stop or auto-toggle.
REQ-028 UPDATE SHALL take priority over a trigger in the same cycle: the trigger is discarded and the new configuration applies.
REQ-029 UPDATE during a WAIT_* state SHALL abandon the pending transition with no SWAP.
REQ-030 IDX_ZERO in the same cycle as the swap SHALL NOT count toward repetitions of the new segment.
REQ-031 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-032 While RESET_N is low: SEGMENT=0, STOP=0, WAITING=0, SWAP=0, state RUN, counter 0, latched config 0, GPIO history 0.
REQ-033 Reset assertion mid-wait SHALL discard the pending transition; first edge after release sees RUN.

Verification
REQ-034 UPDATE(seg=1, mode=00, REP=FFFF); IDX_ZERO 5 cycles later -> SEGMENT 0->1 exactly one cycle after IDX_ZERO, SWAP one cycle, WAITING low.
REQ-035 UPDATE(seg=1, mode=01, value=1000) at SYS_TIME=990 -> SEGMENT=1 at SYS_TIME 1001; value=500 -> swap on first wait cycle.
REQ-036 UPDATE(seg=1, mode=02, value=2); pulse GPIO_IN[1] then GPIO_IN[2] -> only the GPIO_IN[2] rising edge swaps.
REQ-037 UPDATE(seg=1, mode=F0, REP=1); 4 IDX_ZERO pulses -> SEGMENT 1, then 0 after pulse 2, then 1 after pulse 4; STOP stays 0. Same with mode 00 -> STOP=1 after second post-swap IDX_ZERO.
REQ-038 UPDATE and IDX_ZERO in same cycle while in WAIT_IDX -> no SWAP; new config pending.
REQ-039 RESET_N low while WAIT_TIME, release, then SYS_TIME passes value -> no swap, SEGMENT=0.

Source files
------------

// File: rtl/segment_transition.sv
// Segment transition controller: switches the active segment on a configurable
// trigger (index wrap, system time, GPIO edge or immediately) and tracks how
// many times the new segment has been repeated.
module segment_transition #(
  parameter int unsigned NumSegment = 2,
  localparam int unsigned SegW = (NumSegment > 1) ? $clog2(NumSegment) : 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            UPDATE,
  input  logic [SegW-1:0] REQ_SEGMENT,
  input  logic [15:0]     REP,
  input  logic [7:0]      TRANSITION_MODE,
  input  logic [63:0]     TRANSITION_VALUE,
  input  logic            IDX_ZERO,
  input  logic [55:0]     SYS_TIME,
  input  logic [3:0]      GPIO_IN,
  output logic [SegW-1:0] SEGMENT,
  output logic            STOP,
  output logic            WAITING,
  output logic            SWAP
);

  localparam int unsigned RepW   = 16;
  localparam int unsigned ModeW  = 8;
  localparam int unsigned TimeW  = 56;
  localparam int unsigned GpioW  = 4;

  localparam logic [ModeW-1:0] ModeSyncIdx = 8'h00;
  localparam logic [ModeW-1:0] ModeSysTime = 8'h01;
  localparam logic [ModeW-1:0] ModeGpio    = 8'h02;
  localparam logic [ModeW-1:0] ModeExt     = 8'hF0;
  localparam logic [RepW-1:0]  RepInfinite = 16'hFFFF;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_IDX  = 2'd1,
    WAIT_TIME = 2'd2,
    WAIT_GPIO = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SegW-1:0]   seg_q, seg_d;
  logic              stop_q, stop_d;
  logic              swap_q, swap_d;
  logic              waiting_q, waiting_d;
  logic [RepW-1:0]   cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic [SegW-1:0]   lseg_q, lseg_d;
  logic [RepW-1:0]   lrep_q, lrep_d;
  logic [ModeW-1:0]  lmode_q, lmode_d;
  logic [TimeW-1:0]  lval_q, lval_d;
  logic [GpioW-1:0]  gpio_prev_q;
  logic              fire;

  logic              mode_ok_c;
  logic              rise_c;
  logic              unused_value_hi;

  // Only the low 56 bits of the mode argument carry meaning.
  assign unused_value_hi = ^TRANSITION_VALUE[63:TimeW];

  // Undefined transition modes make UPDATE a no-op.
  assign mode_ok_c = (TRANSITION_MODE == ModeSyncIdx) || (TRANSITION_MODE == ModeSysTime) ||
                     (TRANSITION_MODE == ModeGpio)    || (TRANSITION_MODE == ModeExt);

  // Rising edge on the GPIO line selected by the latched value.
  assign rise_c = GPIO_IN[lval_q[1:0]] & ~gpio_prev_q[lval_q[1:0]];

  assign SEGMENT = seg_q;
  assign STOP    = stop_q;
  assign WAITING = waiting_q;
  assign SWAP    = swap_q;

  // State, configuration and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= RUN;
      seg_q       <= '0;
      stop_q      <= 1'b0;
      swap_q      <= 1'b0;
      waiting_q   <= 1'b0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      lseg_q      <= '0;
      lrep_q      <= '0;
      lmode_q     <= '0;
      lval_q      <= '0;
      gpio_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      stop_q      <= stop_d;
      swap_q      <= swap_d;
      waiting_q   <= waiting_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      lseg_q      <= lseg_d;
      lrep_q      <= lrep_d;
      lmode_q     <= lmode_d;
      lval_q      <= lval_d;
      gpio_prev_q <= GPIO_IN;
    end
  end

  // Next-state: UPDATE wins over any trigger; otherwise wait for the trigger
  // or count repetitions of the active segment once it has been swapped in.
  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    stop_d    = stop_q;
    swap_d    = 1'b0;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    lseg_d    = lseg_q;
    lrep_d    = lrep_q;
    lmode_d   = lmode_q;
    lval_d    = lval_q;
    fire      = 1'b0;

    if (UPDATE && mode_ok_c) begin
      lseg_d  = REQ_SEGMENT;
      lrep_d  = REP;
      lmode_d = TRANSITION_MODE;
      lval_d  = TRANSITION_VALUE[TimeW-1:0];
      stop_d  = 1'b0;
      cnt_d   = '0;
      armed_d = 1'b0;
      case (TRANSITION_MODE)
        ModeSyncIdx: state_d = WAIT_IDX;
        ModeSysTime: state_d = WAIT_TIME;
        ModeGpio:    state_d = WAIT_GPIO;
        default: begin
          state_d = RUN;
          seg_d   = REQ_SEGMENT;
          swap_d  = 1'b1;
          armed_d = 1'b1;
        end
      endcase
    end else begin
      case (state_q)
        RUN: begin
          // An index wrap in the swap cycle belongs to the old segment.
          if (armed_q && !stop_q && !swap_q && (lrep_q != RepInfinite) && IDX_ZERO) begin
            cnt_d = cnt_q + RepW'(1);
            // cnt_q == REP means this wrap brings the count to REP+1.
            if (cnt_q == lrep_q) begin
              if (lmode_q == ModeExt) begin
                seg_d  = seg_q ^ SegW'(1);
                swap_d = 1'b1;
                cnt_d  = '0;
              end else begin
                stop_d = 1'b1;
              end
            end
          end
        end
        WAIT_IDX:  fire = IDX_ZERO;
        WAIT_TIME: fire = (SYS_TIME >= lval_q);
        WAIT_GPIO: fire = rise_c;
        default:   state_d = RUN;
      endcase

      if (fire) begin
        state_d = RUN;
        seg_d   = lseg_q;
        swap_d  = 1'b1;
        cnt_d   = '0;
        armed_d = 1'b1;
      end
    end

    waiting_d = (state_d != RUN);
  end

endmodule

// File: tb/tb_segment_transition.sv
// Self-checking bench for segment_transition: directed scenarios followed by
// randomized traffic, all compared against a behavioural model every cycle.
module tb_segment_transition;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        UPDATE;
  logic [0:0]  REQ_SEGMENT;
  logic [15:0] REP;
  logic [7:0]  TRANSITION_MODE;
  logic [63:0] TRANSITION_VALUE;
  logic        IDX_ZERO;
  logic [55:0] sys_time;
  logic [3:0]  GPIO_IN;
  logic [0:0]  SEGMENT;
  logic        STOP;
  logic        WAITING;
  logic        SWAP;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit          m_seg;
  bit          m_stop;
  bit          m_swap;
  int          m_wait;     // 0 none, 1 index wrap, 2 system time, 3 gpio edge
  bit          p_seg;
  int          p_rep;
  bit          p_ext;
  logic [55:0] p_time;
  int          p_sel;
  bit          counting;
  int          seen;
  logic [3:0]  m_ghist;

  segment_transition dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .UPDATE           (UPDATE),
    .REQ_SEGMENT      (REQ_SEGMENT),
    .REP              (REP),
    .TRANSITION_MODE  (TRANSITION_MODE),
    .TRANSITION_VALUE (TRANSITION_VALUE),
    .IDX_ZERO         (IDX_ZERO),
    .SYS_TIME         (sys_time),
    .GPIO_IN          (GPIO_IN),
    .SEGMENT          (SEGMENT),
    .STOP             (STOP),
    .WAITING          (WAITING),
    .SWAP             (SWAP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seg = 0; m_stop = 0; m_swap = 0; m_wait = 0;
    p_seg = 0; p_rep = 0; p_ext = 0; p_time = '0; p_sel = 0;
    counting = 0; seen = 0; m_ghist = '0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_apply();
    bit nswap;
    bit rise;
    bit fired;
    nswap = 0;
    if (!RESET_N) return;
    rise = GPIO_IN[p_sel] && !m_ghist[p_sel];
    if (UPDATE && (TRANSITION_MODE == 8'h00 || TRANSITION_MODE == 8'h01 ||
                   TRANSITION_MODE == 8'h02 || TRANSITION_MODE == 8'hF0)) begin
      p_seg  = REQ_SEGMENT[0];
      p_rep  = int'(REP);
      p_ext  = (TRANSITION_MODE == 8'hF0);
      p_time = TRANSITION_VALUE[55:0];
      p_sel  = int'(TRANSITION_VALUE[1:0]);
      m_stop = 0;
      seen   = 0;
      if (p_ext) begin
        m_seg = REQ_SEGMENT[0]; nswap = 1; m_wait = 0; counting = 1;
      end else begin
        m_wait = int'(TRANSITION_MODE) + 1;
        counting = 0;
      end
    end else if (m_wait != 0) begin
      fired = (m_wait == 1 && IDX_ZERO) || (m_wait == 2 && sys_time >= p_time) ||
              (m_wait == 3 && rise);
      if (fired) begin
        m_seg = p_seg; nswap = 1; m_wait = 0; counting = 1; seen = 0;
      end
    end else if (counting && !m_stop && !m_swap && p_rep != 65535 && IDX_ZERO) begin
      seen++;
      if (seen == p_rep + 1) begin
        if (p_ext) begin
          m_seg = !m_seg; nswap = 1; seen = 0;
        end else begin
          m_stop = 1;
        end
      end
    end
    m_swap  = nswap;
    m_ghist = GPIO_IN;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_apply();
    #1 sys_time = sys_time + 56'd1;
    @(negedge CLK);
    chk("segment", 64'(SEGMENT), 64'(m_seg));
    chk("stop",    64'(STOP),    64'(m_stop));
    chk("waiting", 64'(WAITING), 64'(m_wait != 0));
    chk("swap",    64'(SWAP),    64'(m_swap));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_idx();
    IDX_ZERO = 1'b1;
    tick();
    IDX_ZERO = 1'b0;
  endtask

  task automatic do_update(input logic s, input logic [15:0] r, input logic [7:0] m,
                           input logic [63:0] v);
    REQ_SEGMENT = s; REP = r; TRANSITION_MODE = m; TRANSITION_VALUE = v;
    UPDATE = 1'b1;
    tick();
    UPDATE = 1'b0;
  endtask

  initial begin
    bit found;
    logic [15:0] reps [5];
    logic [7:0]  modes [6];
    reps  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'hFFFF};
    modes = '{8'h00, 8'h01, 8'h02, 8'hF0, 8'h05, 8'hFF};

    RESET_N = 1'b0; UPDATE = 1'b0; REQ_SEGMENT = '0; REP = '0; TRANSITION_MODE = '0;
    TRANSITION_VALUE = '0; IDX_ZERO = 1'b0; sys_time = 56'd100; GPIO_IN = '0;
    model_reset();
    idle(2);
    chk("rst_segment", 64'(SEGMENT), 64'd0);
    chk("rst_stop",    64'(STOP),    64'd0);
    chk("rst_waiting", 64'(WAITING), 64'd0);
    chk("rst_swap",    64'(SWAP),    64'd0);
    RESET_N = 1'b1;
    idle(2);

    // Index-wrap trigger, infinite repetitions
    do_update(1'b1, 16'hFFFF, 8'h00, 64'd0);
    chk("idx_waiting", 64'(WAITING), 64'd1);
    idle(4);
    pulse_idx();
    chk("idx_segment", 64'(SEGMENT), 64'd1);
    chk("idx_swap",    64'(SWAP),    64'd1);
    tick();
    chk("idx_swap_off", 64'(SWAP),    64'd0);
    chk("idx_wait_off", 64'(WAITING), 64'd0);

    // System time trigger in the future
    do_update(1'b0, 16'hFFFF, 8'hF0, 64'd0);
    idle(1);
    sys_time = 56'd990;
    do_update(1'b1, 16'hFFFF, 8'h01, 64'd1000);
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      tick();
      if (SEGMENT == 1'b1) found = 1;
    end
    chk("time_reached", 64'(found), 64'd1);
    chk("time_at",      64'(sys_time), 64'd1001);

    // System time already in the past
    do_update(1'b0, 16'hFFFF, 8'hF0, 64'd0);
    idle(1);
    do_update(1'b1, 16'hFFFF, 8'h01, 64'd500);
    chk("past_pending", 64'(SEGMENT), 64'd0);
    tick();
    chk("past_segment", 64'(SEGMENT), 64'd1);
    chk("past_swap",    64'(SWAP),    64'd1);

    // GPIO edge on the selected line only
    do_update(1'b0, 16'hFFFF, 8'hF0, 64'd0);
    idle(1);
    do_update(1'b1, 16'hFFFF, 8'h02, 64'd2);
    GPIO_IN = 4'b0010; tick();
    GPIO_IN = 4'b0000; tick();
    chk("gpio_other_seg",  64'(SEGMENT), 64'd0);
    chk("gpio_other_wait", 64'(WAITING), 64'd1);
    GPIO_IN = 4'b0100; tick();
    chk("gpio_segment", 64'(SEGMENT), 64'd1);
    chk("gpio_swap",    64'(SWAP),    64'd1);
    GPIO_IN = 4'b0000; idle(2);

    // Immediate swap with auto-alternation every REP+1 wraps
    do_update(1'b1, 16'd1, 8'hF0, 64'd0);
    chk("ext_seg0", 64'(SEGMENT), 64'd1);
    idle(1);
    pulse_idx(); idle(1);
    pulse_idx();
    chk("ext_seg2", 64'(SEGMENT), 64'd0);
    idle(1);
    pulse_idx(); idle(1);
    pulse_idx();
    chk("ext_seg4",  64'(SEGMENT), 64'd1);
    chk("ext_stop",  64'(STOP),    64'd0);
    idle(1);

    // Finite repetitions with a non-immediate mode end in STOP
    do_update(1'b1, 16'd1, 8'h00, 64'd0);
    pulse_idx();
    chk("rep_swap_same", 64'(SWAP), 64'd1);
    idle(1);
    pulse_idx(); idle(1);
    chk("rep_stop_early", 64'(STOP), 64'd0);
    pulse_idx();
    chk("rep_stop", 64'(STOP),    64'd1);
    chk("rep_seg",  64'(SEGMENT), 64'd1);
    idle(2);

    // UPDATE coinciding with the trigger discards the trigger
    do_update(1'b0, 16'hFFFF, 8'h00, 64'd0);
    idle(1);
    IDX_ZERO = 1'b1;
    do_update(1'b0, 16'hFFFF, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF);
    IDX_ZERO = 1'b0;
    chk("prio_swap",    64'(SWAP),    64'd0);
    chk("prio_segment", 64'(SEGMENT), 64'd1);
    chk("prio_waiting", 64'(WAITING), 64'd1);
    pulse_idx();
    chk("prio_still", 64'(SEGMENT), 64'd1);

    // Reset while waiting on time drops the pending swap
    do_update(1'b0, 16'hFFFF, 8'hF0, 64'd0);
    idle(1);
    do_update(1'b1, 16'hFFFF, 8'h01, 64'(sys_time) + 64'd10);
    idle(2);
    RESET_N = 1'b0;
    model_reset();
    tick();
    chk("mid_rst_waiting", 64'(WAITING), 64'd0);
    RESET_N = 1'b1;
    idle(20);
    chk("mid_rst_segment", 64'(SEGMENT), 64'd0);
    chk("mid_rst_waiting2", 64'(WAITING), 64'd0);
    pulse_idx(); idle(1);
    chk("mid_rst_nostop", 64'(STOP), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      UPDATE = ($urandom_range(0, 11) == 0);
      if (UPDATE) begin
        REQ_SEGMENT = 1'($urandom_range(0, 1));
        REP = reps[$urandom_range(0, 4)];
        TRANSITION_MODE = modes[$urandom_range(0, 5)];
        if (TRANSITION_MODE == 8'h01)
          TRANSITION_VALUE = 64'(sys_time) + 64'($urandom_range(0, 40)) - 64'd15;
        else
          TRANSITION_VALUE = {$urandom, $urandom};
      end
      IDX_ZERO = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) GPIO_IN = 4'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        RESET_N = 1'b0;
        model_reset();
        tick();
        RESET_N = 1'b1;
      end else begin
        tick();
      end
    end
    UPDATE = 1'b0; IDX_ZERO = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
